// File: rtl/reg_pair_digest_pkg.sv
// reg_pair_digest_pkg: shared widths, FSM states and key-word helper for the pair digest engine
package reg_pair_digest_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 32;
  localparam int KEY_W = 16;
  localparam int ROT_AMT = 5;
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  function automatic logic [DATA_W-1:0] key_word(input logic [KEY_W-1:0] k);
    return {k, ~k};
  endfunction
endpackage

// File: rtl/reg_pair_digest_if.sv
// reg_pair_digest_if: control, register-file read port and result bundle of the digest engine
interface reg_pair_digest_if;
  import reg_pair_digest_pkg::*;
  logic start;
  logic [ADDR_W-1:0] base_addr;
  logic [ADDR_W-1:0] len;
  logic [KEY_W-1:0] key_in;
  logic [ADDR_W-1:0] rf_reg1;
  logic [ADDR_W-1:0] rf_reg2;
  logic [DATA_W-1:0] rf_rdata1;
  logic [DATA_W-1:0] rf_rdata2;
  logic busy;
  logic done;
  logic [DATA_W-1:0] digest;
  modport master (
    output start, base_addr, len, key_in, rf_rdata1, rf_rdata2,
    input rf_reg1, rf_reg2, busy, done, digest
  );
  modport slave (
    input start, base_addr, len, key_in, rf_rdata1, rf_rdata2,
    output rf_reg1, rf_reg2, busy, done, digest
  );
endinterface

// File: rtl/reg_pair_digest_fold.sv
// reg_pair_digest_fold: one combinational fold step of a word pair into the running digest
module reg_pair_digest_fold
  import reg_pair_digest_pkg::*;
(
  input  logic [DATA_W-1:0] acc,
  input  logic [DATA_W-1:0] rdata1,
  input  logic [DATA_W-1:0] rdata2,
  input  logic [KEY_W-1:0]  key,
  output logic [DATA_W-1:0] acc_nx
);
  assign acc_nx = ((acc << ROT_AMT) | (acc >> (DATA_W - ROT_AMT))) ^ (rdata1 + rdata2) ^ key_word(key);
endmodule

// File: rtl/reg_pair_digest.sv
// reg_pair_digest: walks LEN word pairs from BASE over the register-file read ports and folds them into a keyed digest
module reg_pair_digest
  import reg_pair_digest_pkg::*;
(
  input logic clk,
  input logic rst_n,
  reg_pair_digest_if.slave bus
);
  state_t state, state_nx;
  logic [ADDR_W-1:0] ptr, cnt, rf_reg1, rf_reg2;
  logic [KEY_W-1:0] key;
  logic [DATA_W-1:0] acc, acc_nx, digest;
  logic vld;
  logic accept;
  assign accept = state == IDLE && bus.start;
  assign bus.busy = state != IDLE;
  assign bus.done = state == DONE;
  assign bus.rf_reg1 = rf_reg1;
  assign bus.rf_reg2 = rf_reg2;
  assign bus.digest = digest;
  reg_pair_digest_fold u_fold (
    .acc    (acc),
    .rdata1 (bus.rf_rdata1),
    .rdata2 (bus.rf_rdata2),
    .key    (key),
    .acc_nx (acc_nx)
  );
  always_ff @(posedge clk)
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (bus.start ? (bus.len == '0 ? DRAIN : ISSUE) : IDLE) :
               state == ISSUE ? (cnt == ADDR_W'(1) ? DRAIN : ISSUE) :
               state == DRAIN ? DONE : IDLE;
  end
  // rf_reg* are registered so they carry pair i's address throughout ISSUE cycle i
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= '0;
      cnt <= '0;
      key <= '0;
      acc <= '0;
      vld <= 1'b0;
      rf_reg1 <= '0;
      rf_reg2 <= '0;
      digest <= '0;
    end else begin
      vld <= state == ISSUE;
      if (accept) begin
        rf_reg1 <= bus.base_addr;
        rf_reg2 <= bus.base_addr + ADDR_W'(1);
        ptr <= bus.base_addr + ADDR_W'(2);
        cnt <= bus.len;
        key <= bus.key_in;
        acc <= key_word(bus.key_in);
      end else if (vld) acc <= acc_nx;
      if (state == ISSUE && cnt != ADDR_W'(1)) begin
        rf_reg1 <= ptr;
        rf_reg2 <= ptr + ADDR_W'(1);
        ptr <= ptr + ADDR_W'(2);
        cnt <= cnt - ADDR_W'(1);
      end
      if (state == DRAIN) digest <= vld ? acc_nx : acc;
    end
  end
endmodule

// File: tb/tb_reg_pair_digest.sv
// tb_reg_pair_digest: directed and random walks against a registered-read register file and a pair-digest reference model
module tb_reg_pair_digest;
  logic clk = 1'b0;
  logic rst_n;
  int checks = 0;
  int errors = 0;
  int starts = 0;
  int done_cnt = 0;
  logic [31:0] mem [1024];
  logic [31:0] last;
  localparam logic [15:0] KEY = 16'h0032;
  reg_pair_digest_if bus ();
  reg_pair_digest dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  always @(posedge clk) begin
    bus.rf_rdata1 <= mem[bus.rf_reg1];
    bus.rf_rdata2 <= mem[bus.rf_reg2];
  end
  always @(posedge clk) if (rst_n && bus.done) done_cnt++;
  function automatic logic [31:0] model(input int b, input int l, input logic [15:0] k);
    logic [31:0] a;
    int p;
    a = {k, ~k};
    for (int i = 0; i < l; i++) begin
      p = (b + 2 * i) % 1024;
      a = {a[26:0], a[31:27]} ^ (mem[p] + mem[(p + 1) % 1024]) ^ {k, ~k};
    end
    return a;
  endfunction
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask
  task automatic fill_mem();
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
  endtask
  task automatic walk(input int b, input int l, input logic [15:0] k, input bit poke);
    logic [31:0] exp;
    int n;
    exp = model(b, l, k);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 10'(b);
    bus.len = 10'(l);
    bus.key_in = k;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.base_addr = '1;
    bus.len = '1;
    bus.key_in = ~k;
    starts++;
    check("busy_walk", 32'(bus.busy), 1);
    n = 0;
    while (!bus.done && n < l + 8) begin
      if (n < l) begin
        check("rf_reg1", 32'(bus.rf_reg1), (b + 2 * n) % 1024);
        check("rf_reg2", 32'(bus.rf_reg2), (b + 2 * n + 1) % 1024);
      end
      bus.start = poke && n == 3;
      @(posedge clk);
      #1;
      n++;
    end
    bus.start = 1'b0;
    check("latency", n + 1, l + 2);
    check("digest", bus.digest, exp);
    last = bus.digest;
    @(posedge clk);
    #1;
    check("done_pulse", 32'(bus.done), 0);
    check("idle", 32'(bus.busy), 0);
  endtask
  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.len = '0;
    bus.key_in = KEY;
    for (int i = 0; i < 1024; i++) mem[i] = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_done", 32'(bus.done), 0);
    check("rst_digest", bus.digest, 0);
    check("rst_reg1", 32'(bus.rf_reg1), 0);
    check("rst_reg2", 32'(bus.rf_reg2), 0);
    rst_n = 1'b1;
    fill_mem();
    walk(0, 0, KEY, 1'b0);
    check("len0_digest", bus.digest, 32'h0032FFCD);
    mem[0] = 32'd1;
    mem[1] = 32'd2;
    walk(0, 1, KEY, 1'b0);
    check("pair_digest", bus.digest, 32'h066D066E);
    walk(1022, 2, KEY, 1'b0);
    walk(300, 8, KEY, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    check("digest_hold", bus.digest, last);
    check("single_done", done_cnt, starts);
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 10'd100;
    bus.len = 10'd8;
    bus.key_in = KEY;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_done", 32'(bus.done), 0);
    check("mid_rst_digest", bus.digest, 0);
    check("mid_rst_reg1", 32'(bus.rf_reg1), 0);
    rst_n = 1'b1;
    walk(100, 8, KEY, 1'b0);
    for (int w = 0; w < 1000; w++) begin
      if (w % 100 == 0) fill_mem();
      walk(int'($urandom_range(0, 1023)), int'($urandom_range(0, 40)), 16'($urandom), 1'b0);
    end
    repeat (2) @(posedge clk);
    check("done_count", done_cnt, starts);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
